// File: rtl/simon_button_conditioner.sv
// Four-button front end: 2-flop sync, per-button debounce, then one-press/one-pulse arbitration.
// Press-to-pulse latency is DEBOUNCE_CYCLES+3 edges. There is no backpressure; accept only gates colour pulses.
module simon_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic SYS_CLK,
    input  logic RESET,
    input  logic btn_yellow,
    input  logic btn_red,
    input  logic btn_blue,
    input  logic btn_green,
    input  logic accept,
    output logic yellow,
    output logic red,
    output logic blue,
    output logic green,
    output logic btn_held,
    output logic conflict
);

    typedef enum logic [1:0] {IDLE, PRESSED, BLOCKED} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       raw;
    logic [3:0]       sync1;
    logic [3:0]       s;
    logic [3:0]       db;
    logic [CNT_W-1:0] cnt [4];
    logic [2:0]       n_db;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] colour_q;
    logic [3:0] colour_nxt;
    logic       conflict_nxt;

    assign raw = {btn_green, btn_blue, btn_red, btn_yellow};

    always_ff @(posedge SYS_CLK or posedge RESET) begin
        if (RESET) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
        end
    end

    // The counter only runs while the synchronised level disagrees with db, so any glitch restarts it.
    always_ff @(posedge SYS_CLK or posedge RESET) begin
        if (RESET) begin
            db <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= s[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign n_db = {2'b00, db[0]} + {2'b00, db[1]} + {2'b00, db[2]} + {2'b00, db[3]};

    always_ff @(posedge SYS_CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            colour_q <= '0;
            conflict <= 1'b0;
            btn_held <= 1'b0;
        end else begin
            state    <= state_nxt;
            colour_q <= colour_nxt;
            conflict <= conflict_nxt;
            btn_held <= |db;
        end
    end

    always_comb begin
        state_nxt    = state;
        colour_nxt   = '0;
        conflict_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (n_db == 3'd1) begin
                    state_nxt = PRESSED;
                    // With exactly one button high, db is already the one-hot colour.
                    if (accept) colour_nxt = db;
                end else if (n_db >= 3'd2) begin
                    state_nxt    = BLOCKED;
                    conflict_nxt = 1'b1;
                end
            end
            PRESSED: begin
                if (n_db == 3'd0)      state_nxt = IDLE;
                else if (n_db >= 3'd2) state_nxt = BLOCKED;
            end
            BLOCKED: begin
                if (n_db == 3'd0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign yellow = colour_q[0];
    assign red    = colour_q[1];
    assign blue   = colour_q[2];
    assign green  = colour_q[3];

endmodule

// File: tb/tb_simon_button_conditioner.sv
// Directed bench for simon_button_conditioner with DEBOUNCE_CYCLES=4.
// A button level driven just after edge e is first sampled at edge e+1, so outputs change on the 7th following tick.
module tb_simon_button_conditioner;

    logic SYS_CLK;
    logic RESET;
    logic btn_yellow, btn_red, btn_blue, btn_green;
    logic accept;
    logic yellow, red, blue, green;
    logic btn_held, conflict;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] Y = 4'b0001;
    localparam logic [3:0] R = 4'b0010;
    localparam logic [3:0] B = 4'b0100;
    localparam logic [3:0] G = 4'b1000;
    localparam logic [3:0] NONE = 4'b0000;

    simon_button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(20)
    ) dut (
        .SYS_CLK   (SYS_CLK),
        .RESET     (RESET),
        .btn_yellow(btn_yellow),
        .btn_red   (btn_red),
        .btn_blue  (btn_blue),
        .btn_green (btn_green),
        .accept    (accept),
        .yellow    (yellow),
        .red       (red),
        .blue      (blue),
        .green     (green),
        .btn_held  (btn_held),
        .conflict  (conflict)
    );

    initial begin
        SYS_CLK = 1'b0;
        forever #5 SYS_CLK = ~SYS_CLK;
    end

    // Output vector layout: {green, blue, red, yellow, conflict, btn_held}
    task automatic check_outs(input logic [3:0] col, input logic conf, input logic held,
                              input string tag);
        logic [5:0] obs;
        logic [5:0] exp;
        obs = {green, blue, red, yellow, conflict, btn_held};
        exp = {col, conf, held};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t: observed gbry_c_h=%b expected %b", tag, $time, obs, exp);
        end
    endtask

    task automatic tick(input logic [3:0] col, input logic conf, input logic held, input string tag);
        @(posedge SYS_CLK);
        #1;
        check_outs(col, conf, held, tag);
    endtask

    // Drive the button levels, then check n ticks: pulse only on tick 7, btn_held h0 before tick 7 and h1 from it.
    task automatic watch(input logic [3:0] b, input logic [3:0] col, input logic conf,
                         input logic h0, input logic h1, input int n, input string tag);
        {btn_green, btn_blue, btn_red, btn_yellow} = b;
        for (int t = 1; t <= n; t++)
            tick((t == 7) ? col : NONE, (t == 7) ? conf : 1'b0, (t >= 7) ? h1 : h0, tag);
    endtask

    initial begin
        RESET = 1'b1;
        accept = 1'b1;
        {btn_green, btn_blue, btn_red, btn_yellow} = NONE;

        tick(NONE, 1'b0, 1'b0, "reset_hold");
        tick(NONE, 1'b0, 1'b0, "reset_hold");
        RESET = 1'b0;
        watch(NONE, NONE, 1'b0, 1'b0, 1'b0, 3, "idle");

        // Clean press and release
        watch(R, R, 1'b0, 1'b0, 1'b1, 20, "clean_press");
        watch(NONE, NONE, 1'b0, 1'b1, 1'b0, 10, "clean_release");

        // Bounce: 1,0,1,0 on successive edges never reaches the debounce count
        btn_yellow = 1'b1; tick(NONE, 1'b0, 1'b0, "bounce");
        btn_yellow = 1'b0; tick(NONE, 1'b0, 1'b0, "bounce");
        btn_yellow = 1'b1; tick(NONE, 1'b0, 1'b0, "bounce");
        btn_yellow = 1'b0; tick(NONE, 1'b0, 1'b0, "bounce");
        watch(Y, Y, 1'b0, 1'b0, 1'b1, 12, "bounce_steady");
        watch(NONE, NONE, 1'b0, 1'b1, 1'b0, 10, "bounce_release");

        // Chord: simultaneous blue+green gives one conflict pulse only
        watch(B | G, NONE, 1'b1, 1'b0, 1'b1, 12, "chord");
        watch(NONE, NONE, 1'b0, 1'b1, 1'b0, 10, "chord_release");
        watch(G, G, 1'b0, 1'b0, 1'b1, 10, "chord_green");
        watch(NONE, NONE, 1'b0, 1'b1, 1'b0, 10, "green_release");

        // Overlap: blue added while red is held is silently blocked
        watch(R, R, 1'b0, 1'b0, 1'b1, 10, "overlap_red");
        watch(R | B, NONE, 1'b0, 1'b1, 1'b1, 12, "overlap_blue");
        watch(NONE, NONE, 1'b0, 1'b1, 1'b0, 10, "overlap_release");
        watch(B, B, 1'b0, 1'b0, 1'b1, 10, "overlap_blue_again");
        watch(NONE, NONE, 1'b0, 1'b1, 1'b0, 10, "blue_release");

        // accept gating
        accept = 1'b0;
        watch(Y, NONE, 1'b0, 1'b0, 1'b1, 10, "accept_low");
        accept = 1'b1;
        watch(Y, NONE, 1'b0, 1'b1, 1'b1, 6, "accept_rise_held");
        watch(NONE, NONE, 1'b0, 1'b1, 1'b0, 10, "accept_release");
        watch(Y, Y, 1'b0, 1'b0, 1'b1, 10, "accept_repress");
        watch(NONE, NONE, 1'b0, 1'b1, 1'b0, 10, "yellow_release");

        // Reset between edges while red is held
        watch(R, R, 1'b0, 1'b0, 1'b1, 10, "pre_reset_red");
        #2;
        RESET = 1'b1;
        #1;
        check_outs(NONE, 1'b0, 1'b0, "reset_async");
        tick(NONE, 1'b0, 1'b0, "reset_held");
        RESET = 1'b0;
        watch(R, R, 1'b0, 1'b0, 1'b1, 12, "post_reset_red");
        watch(NONE, NONE, 1'b0, 1'b1, 1'b0, 10, "post_reset_release");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
